// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - data/control bundle between a host and the display scan controller
// Purpose: groups the host-side load inputs and the display-side outputs.
// Signals:
//   value       host -> ctrl  BCD digits, digit i at [4i+3:4i]
//   load        host -> ctrl  one-cycle capture strobe for value
//   blank_lz    host -> ctrl  leading-zero blanking enable
//   digit_bcd   ctrl -> host  BCD code for the shared decoder
//   digit_en_n  ctrl -> host  active-low anode enables
//   load_ack    ctrl -> host  pending data applied (first cycle of slot 0)
//   frame_start ctrl -> host  first cycle of slot 0
//   bcd_err     ctrl -> host  current slot digit is > 9
interface display_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value;
    logic                  load;
    logic                  blank_lz;
    logic [3:0]            digit_bcd;
    logic [N_DIGITS-1:0]   digit_en_n;
    logic                  load_ack;
    logic                  frame_start;
    logic                  bcd_err;

    modport master (
        output value, load, blank_lz,
        input  digit_bcd, digit_en_n, load_ack, frame_start, bcd_err
    );

    modport slave (
        input  value, load, blank_lz,
        output digit_bcd, digit_en_n, load_ack, frame_start, bcd_err
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - time-multiplexed seven-segment scan controller
// Purpose: rotates one digit slot at a time through N_DIGITS, presenting the
//   shadow digit to the shared decoder, with per-slot dead time, leading-zero
//   blanking, non-BCD flagging and tear-free frame-boundary updates.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    display_scan_ctrl_if slave modport (value/load/blank_lz in,
//          digit_bcd/digit_en_n/load_ack/frame_start/bcd_err out)
module display_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_scan_ctrl_if.slave   bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VW = 4 * N_DIGITS;

    typedef enum logic {S_DEAD, S_ON} slot_state_t;

    slot_state_t           r_state;
    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [VW-1:0]         r_shadow;
    logic [VW-1:0]         r_pend;
    logic                  r_pend_v;
    logic [3:0]            r_digit_bcd;
    logic [N_DIGITS-1:0]   r_digit_en_n;
    logic                  r_load_ack;
    logic                  r_frame_start;
    logic                  r_bcd_err;

    slot_state_t           w_state_nxt;
    logic                  w_presc_last;
    logic                  w_idx_last;
    logic                  w_boundary;
    logic                  w_xfer;
    logic [PW-1:0]         w_presc_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [VW-1:0]         w_shadow_nxt;
    logic [3:0]            w_digit_nxt;
    logic                  w_run_zero;
    logic                  w_lz;
    logic                  w_blanked;
    logic                  w_err_nxt;
    logic [N_DIGITS-1:0]   w_en_n_nxt;

    // Outputs are registered from next-state values so they line up with the
    // counters without an extra cycle of lag.
    always_comb begin
        w_presc_last = (r_presc == PW'(SCAN_DIV - 1));
        w_idx_last   = (r_idx == IW'(N_DIGITS - 1));
        w_boundary   = w_presc_last && w_idx_last;

        w_presc_nxt = w_presc_last ? '0 : r_presc + 1'b1;
        w_idx_nxt   = r_idx;
        if (w_presc_last) begin
            w_idx_nxt = w_idx_last ? '0 : r_idx + 1'b1;
        end

        // A load landing on the boundary itself wins over the pending copy.
        w_xfer       = w_boundary && (bus.load || r_pend_v);
        w_shadow_nxt = r_shadow;
        if (w_boundary && bus.load) begin
            w_shadow_nxt = bus.value;
        end else if (w_boundary && r_pend_v) begin
            w_shadow_nxt = r_pend;
        end

        w_digit_nxt = w_shadow_nxt[4*int'(w_idx_nxt) +: 4];
        w_err_nxt   = (w_digit_nxt > 4'd9);

        // Walk from the most significant digit down; the digit is a leading
        // zero if it and everything above it are zero.
        w_run_zero = 1'b1;
        w_lz       = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_run_zero = w_run_zero && (w_shadow_nxt[4*i +: 4] == 4'd0);
            if (i == int'(w_idx_nxt)) begin
                w_lz = w_run_zero;
            end
        end
        w_blanked = bus.blank_lz && (w_idx_nxt != '0) && w_lz;

        w_state_nxt = r_state;
        case (r_state)
            S_DEAD:  if (w_presc_nxt == PW'(DEAD_CYCLES)) w_state_nxt = S_ON;
            S_ON:    if (w_presc_last) w_state_nxt = S_DEAD;
            default: w_state_nxt = S_DEAD;
        endcase

        w_en_n_nxt = '1;
        if (w_state_nxt == S_ON && !w_err_nxt && !w_blanked) begin
            w_en_n_nxt[w_idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_DEAD;
            r_presc       <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_pend        <= '0;
            r_pend_v      <= 1'b0;
            r_digit_bcd   <= 4'd0;
            r_digit_en_n  <= '1;
            r_load_ack    <= 1'b0;
            r_frame_start <= 1'b0;
            r_bcd_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_presc       <= w_presc_nxt;
            r_idx         <= w_idx_nxt;
            r_shadow      <= w_shadow_nxt;
            if (bus.load && !w_boundary) begin
                r_pend   <= bus.value;
                r_pend_v <= 1'b1;
            end else if (w_boundary) begin
                r_pend_v <= 1'b0;
            end
            r_digit_bcd   <= w_digit_nxt;
            r_digit_en_n  <= w_en_n_nxt;
            r_bcd_err     <= w_err_nxt;
            r_frame_start <= w_boundary;
            r_load_ack    <= w_xfer;
        end
    end

    assign bus.digit_bcd   = r_digit_bcd;
    assign bus.digit_en_n  = r_digit_en_n;
    assign bus.load_ack    = r_load_ack;
    assign bus.frame_start = r_frame_start;
    assign bus.bcd_err     = r_bcd_err;
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display built around the shared 4-bit BCD-to-segment decoder. It owns the shared decoder and enables one digit at a time, in a fixed rotation. For each digit it presents that digit's BCD code on `digit_bcd` and drives the matching anode enable. Updates arriving mid-frame are held and take effect only at a frame boundary, which prevents tearing. The block also applies leading-zero blanking, inserts a ghosting dead-time at the start of every slot, and flags non-BCD digits.

## Interface
- `N_DIGITS`, 4: number of digits scanned; legal range 1..8.
- `SCAN_DIV`, 1000: clock cycles per digit slot; must be > `DEAD_CYCLES`.
- `DEAD_CYCLES`, 16: cycles at the start of each slot with all anodes off; legal range ≥ 1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `value` input 4*N_DIGITS: BCD digits; digit i is `value[4i+3:4i]`; digit 0 is least significant.
- `load` input 1: one-cycle strobe that captures `value` into the pending register.
- `blank_lz` input 1: 1 enables leading-zero blanking; sampled every cycle.
- `digit_bcd` output 4: BCD code to the shared decoder for the current slot.
- `digit_en_n` output N_DIGITS: anode enables, active-low; at most one bit is low at any time.
- `load_ack` output 1: one-cycle pulse when pending data has been applied to the display.
- `frame_start` output 1: one-cycle pulse on the first cycle of slot 0.
- `bcd_err` output 1: high for the whole slot whose digit is > 9.

## Operation
- Registers:
  - `presc`: counts 0..SCAN_DIV-1.
  - `idx`: counts 0..N_DIGITS-1.
  - `shadow`: value currently displayed.
  - `pend` / `pend_v`: pending value and its valid flag.
- Counting: `presc` increments every cycle. When `presc` = SCAN_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps from N_DIGITS-1 to 0.
- Boundary cycle: the cycle with `presc` = SCAN_DIV-1 and `idx` = N_DIGITS-1.
- Slot FSM, decoded from `presc`:
  - DEAD (`presc` < DEAD_CYCLES): all `digit_en_n` = 1.
  - ON (otherwise): `digit_en_n[idx]` = 0 unless the digit is suppressed.
- Suppressed digit: the digit is blanked by leading-zero blanking or is > 9. A suppressed digit keeps all anodes off for the entire slot.
- `digit_bcd` equals shadow digit `idx` for the whole slot, blanked or not.
- Leading-zero blanking: when `blank_lz` = 1, digit i is blanked if digit i and all higher digits of `shadow` are 0. Digit 0 is never blanked.
- `bcd_err`: equals 1 throughout any slot whose shadow digit is > 9.
- Load handling:
  - `load` = 1 writes `value` into `pend` and sets `pend_v`.
  - A second load before the boundary overwrites `pend`; only one ack results.
  - In the boundary cycle, if `pend_v` = 1, `pend` is copied to `shadow` and `pend_v` clears.
  - `load` asserted in the boundary cycle itself bypasses `pend`: that cycle's `value` goes straight to `shadow`.
- `load_ack` and `frame_start`: registered pulses in the cycle after the boundary cycle (first cycle of slot 0). `load_ack` fires only if a transfer occurred.
- Reset (asynchronous, any time, including mid-slot):
  - Counters, `shadow`, `pend` and `pend_v` clear to 0.
  - Outputs go to `digit_en_n` all 1, `digit_bcd` = 0, `load_ack` = 0, `frame_start` = 0, `bcd_err` = 0.

## Timing
- All outputs are registered and decoded from next-state, so they align with the counter values defined above; there is no extra lag.
- Cycle 0 is the first rising edge after `rst_n` rises. It starts slot 0 in DEAD with `presc` = 0.
- First `frame_start` is at cycle N_DIGITS·SCAN_DIV, then every N_DIGITS·SCAN_DIV cycles.
- Digit k's anode is low from cycle (k·SCAN_DIV + DEAD_CYCLES) through ((k+1)·SCAN_DIV − 1), relative to frame start.
- Load-to-display latency ranges from 1 cycle (load in the boundary cycle) to N_DIGITS·SCAN_DIV cycles.
- `load_ack` coincides with `frame_start`.
- `blank_lz` changes take effect in the next cycle, even mid-slot.

## Test plan
- Reset values: set `SCAN_DIV`=8, `DEAD_CYCLES`=2, `N_DIGITS`=4 (same for all scenarios below). Hold `rst_n` = 0 → `digit_en_n`=4'b1111, `digit_bcd`=0, `load_ack`=`frame_start`=`bcd_err`=0. Release reset → `digit_en_n[0]` low cycles 2–7, `digit_en_n[1]` low cycles 10–15, and so on; `frame_start` at cycle 32.
- Leading-zero blanking: load `value`=16'h0042 with `blank_lz`=1 → anodes 0 and 1 pulse; anodes 2 and 3 stay 1 for the whole frame. Same with `blank_lz`=0 → all four pulse. Load 16'h0000 with `blank_lz`=1 → only digit 0 lights, with `digit_bcd`=0.
- Held load: load 16'h1234 at cycle 5 → `digit_bcd` keeps old values until cycle 32. From cycle 32, `load_ack`=1 and `frame_start`=1; slot 0 shows 4, slot 1 shows 3.
- Overwritten load and boundary bypass: load 16'h1111 at cycle 3, then 16'h2222 at cycle 20 → a single `load_ack` at cycle 32 and `shadow`=16'h2222. Load 16'h5555 exactly at cycle 31 → slot 0 of the next frame shows 5.
- Non-BCD digit: load 16'h00A1 → slot 1 has `bcd_err`=1 for all 8 cycles with anodes all 1. Slot 0 shows 1 with `bcd_err`=0.
- Reset mid-operation: pulse `rst_n` low for 1 cycle at cycle 13 → outputs return to reset values immediately, `shadow` reads 0, and scanning restarts from slot 0.
